// File: rtl/mandelbrot_iter_engine_if.sv
// Handshake bundle for the Mandelbrot iteration engine.
//   in_valid/in_ready  : point offer, accepted when both are high at a rising edge
//   in_cre/in_cim      : c real/imag, signed fixed point, W bits each
//   in_x/in_y          : pixel tags carried unmodified to the result
//   out_valid/out_ready: result offer, consumed when both are high at a rising edge
//   out_x/out_y        : tags of the result
//   out_iter           : iteration count at retirement
//   out_escaped        : 1 = retired on |z|^2 > 4, 0 = retired on the iteration cap
// The master drives points and consumes results; the slave is the engine.
interface mandelbrot_iter_engine_if #(
  parameter int W      = 32,
  parameter int COORDW = 11,
  parameter int ITW    = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_cre;
  logic [W-1:0]      in_cim;
  logic [COORDW-1:0] in_x;
  logic [COORDW-1:0] in_y;
  logic              out_valid;
  logic              out_ready;
  logic [COORDW-1:0] out_x;
  logic [COORDW-1:0] out_y;
  logic [ITW-1:0]    out_iter;
  logic              out_escaped;

  modport master (
    output in_valid, in_cre, in_cim, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_iter, out_escaped
  );

  modport slave (
    input  in_valid, in_cre, in_cim, in_x, in_y, out_ready,
    output in_ready, out_valid, out_x, out_y, out_iter, out_escaped
  );
endinterface

// File: rtl/mandelbrot_iter_engine.sv
// Mandelbrot iteration engine: a non-stalling recirculation ring of DEPTH
// slots computes z = z^2 + c for several points at once; retired points are
// written into a reorder buffer so results leave in acceptance order.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mandelbrot_iter_engine_if (input points, results)
module mandelbrot_iter_engine #(
  parameter int W      = 32,
  parameter int FRAC   = 28,
  parameter int COORDW = 11,
  parameter int ITW    = 16,
  parameter int IMAX   = 15,
  parameter int DEPTH  = 4,
  parameter int ROBW   = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  mandelbrot_iter_engine_if.slave bus
);

  localparam int ROB_N = 2 ** ROBW;
  localparam int IFW   = ROBW + 1;
  localparam int SW    = 2 * W + 1;
  // |z|^2 > 4 in Q(2*FRAC) squared units
  localparam logic [SW-1:0]  ESC_LIMIT = SW'(1) << (2 * FRAC + 2);
  localparam logic [ITW-1:0] K_CAP     = ITW'(IMAX);
  localparam logic [IFW-1:0] INF_MAX   = IFW'(ROB_N);

  typedef struct packed {
    logic              valid;
    logic [W-1:0]      cre;
    logic [W-1:0]      cim;
    logic [W-1:0]      zx;
    logic [W-1:0]      zy;
    logic [ITW-1:0]    k;
    logic              flag;
    logic [COORDW-1:0] x;
    logic [COORDW-1:0] y;
    logic [ROBW-1:0]   seq;
  } slot_t;

  slot_t ring_q [DEPTH];
  slot_t ring_d [DEPTH];
  slot_t newSlot;
  slot_t src;

  logic              robValid_q [ROB_N];
  logic [COORDW-1:0] robX_q     [ROB_N];
  logic [COORDW-1:0] robY_q     [ROB_N];
  logic [ITW-1:0]    robIter_q  [ROB_N];
  logic              robEsc_q   [ROB_N];

  logic [ROBW-1:0] nextSeq_q, nextSeq_d;
  logic [ROBW-1:0] headPtr_q, headPtr_d;
  logic [IFW-1:0]  inflight_q, inflight_d;

  logic oldRetire, newRetire, iterate, inReady, accept, outValid, consume;

  logic signed [W-1:0]   zx, zy, cr, ci, nzx, nzy;
  logic signed [2*W-1:0] zxSq, zySq, zxzy, nzxSq, nzySq;
  logic signed [2*W:0]   sqDiff;
  logic [SW-1:0]         magSq;

  // Head control. A freshly admitted point takes the place of the head slot
  // in the same cycle, so it is iterated (or, with IMAX=0, retired) at once.
  // Admission uses the registered inflight count, so a consume happening in
  // the same cycle cannot open admission early.
  always_comb begin
    newSlot       = '0;
    newSlot.valid = 1'b1;
    newSlot.cre   = bus.in_cre;
    newSlot.cim   = bus.in_cim;
    newSlot.x     = bus.in_x;
    newSlot.y     = bus.in_y;
    newSlot.seq   = nextSeq_q;

    oldRetire = ring_q[0].valid && (ring_q[0].flag || (ring_q[0].k == K_CAP));
    inReady   = rst_n && (!ring_q[0].valid || oldRetire) && (inflight_q < INF_MAX);
    accept    = bus.in_valid && inReady;
    newRetire = accept && (IMAX == 0);
    src       = accept ? newSlot : ring_q[0];
    iterate   = accept ? (IMAX != 0) : (ring_q[0].valid && !oldRetire);

    outValid  = robValid_q[headPtr_q];
    consume   = outValid && bus.out_ready;

    nextSeq_d  = accept  ? nextSeq_q + ROBW'(1) : nextSeq_q;
    headPtr_d  = consume ? headPtr_q + ROBW'(1) : headPtr_q;
    inflight_d = inflight_q;
    if (accept && !consume) begin
      inflight_d = inflight_q + IFW'(1);
    end else if (!accept && consume) begin
      inflight_d = inflight_q - IFW'(1);
    end
  end

  // One iteration step on the head slot. The cross term uses a shift one
  // short of FRAC to fold in the factor of two. The escape test is done on
  // the new z at full width so large squares cannot wrap into a false "inside".
  always_comb begin
    zx     = src.zx;
    zy     = src.zy;
    cr     = src.cre;
    ci     = src.cim;
    zxSq   = zx * zx;
    zySq   = zy * zy;
    zxzy   = zx * zy;
    sqDiff = {zxSq[2*W-1], zxSq} - {zySq[2*W-1], zySq};
    nzx    = W'(sqDiff >>> FRAC) + cr;
    nzy    = W'(zxzy >>> (FRAC - 1)) + ci;
    nzxSq  = nzx * nzx;
    nzySq  = nzy * nzy;
    magSq  = {1'b0, nzxSq} + {1'b0, nzySq};
  end

  // Ring advance: every slot moves one step toward the head; the iterated
  // head re-enters at the tail and is back at the head DEPTH cycles later.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      ring_d[i] = ring_q[i + 1];
    end
    ring_d[DEPTH-1] = '0;
    if (iterate) begin
      ring_d[DEPTH-1]      = src;
      ring_d[DEPTH-1].zx   = nzx;
      ring_d[DEPTH-1].zy   = nzy;
      ring_d[DEPTH-1].k    = src.k + ITW'(1);
      ring_d[DEPTH-1].flag = magSq > ESC_LIMIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      nextSeq_q  <= '0;
      headPtr_q  <= '0;
      inflight_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= ring_d[i];
      end
      nextSeq_q  <= nextSeq_d;
      headPtr_q  <= headPtr_d;
      inflight_q <= inflight_d;
    end
  end

  // Reorder buffer. A retiring point lands in its own sequence entry, which
  // is never the entry being consumed, so the two writes cannot collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_N; i++) begin
        robValid_q[i] <= 1'b0;
        robX_q[i]     <= '0;
        robY_q[i]     <= '0;
        robIter_q[i]  <= '0;
        robEsc_q[i]   <= 1'b0;
      end
    end else begin
      if (consume) begin
        robValid_q[headPtr_q] <= 1'b0;
      end
      if (oldRetire) begin
        robValid_q[ring_q[0].seq] <= 1'b1;
        robX_q[ring_q[0].seq]     <= ring_q[0].x;
        robY_q[ring_q[0].seq]     <= ring_q[0].y;
        robIter_q[ring_q[0].seq]  <= ring_q[0].k;
        robEsc_q[ring_q[0].seq]   <= ring_q[0].flag;
      end
      if (newRetire) begin
        robValid_q[nextSeq_q] <= 1'b1;
        robX_q[nextSeq_q]     <= newSlot.x;
        robY_q[nextSeq_q]     <= newSlot.y;
        robIter_q[nextSeq_q]  <= '0;
        robEsc_q[nextSeq_q]   <= 1'b0;
      end
    end
  end

  // Result data is forced to zero whenever nothing valid is presented.
  assign bus.in_ready    = inReady;
  assign bus.out_valid   = outValid;
  assign bus.out_x       = outValid ? robX_q[headPtr_q]    : '0;
  assign bus.out_y       = outValid ? robY_q[headPtr_q]    : '0;
  assign bus.out_iter    = outValid ? robIter_q[headPtr_q] : '0;
  assign bus.out_escaped = outValid ? robEsc_q[headPtr_q]  : 1'b0;

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Self-checking bench for mandelbrot_iter_engine: expected results are pushed
// into a scoreboard queue on acceptance and compared as results appear.
module tb_mandelbrot_iter_engine;
  localparam int W      = 32;
  localparam int FRAC   = 28;
  localparam int COORDW = 11;
  localparam int ITW    = 16;
  localparam int IMAX   = 15;
  localparam int DEPTH  = 4;
  localparam int ROBW   = 3;
  localparam int ONE    = 1 << FRAC;

  typedef struct packed {
    logic [COORDW-1:0] x;
    logic [COORDW-1:0] y;
    logic [ITW-1:0]    iter;
    logic              esc;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  res_t sbQ[$];

  mandelbrot_iter_engine_if #(.W(W), .COORDW(COORDW), .ITW(ITW)) bus();

  mandelbrot_iter_engine #(
    .W(W), .FRAC(FRAC), .COORDW(COORDW), .ITW(ITW),
    .IMAX(IMAX), .DEPTH(DEPTH), .ROBW(ROBW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic res_t mkRes(input int x, input int y, input int it, input logic esc);
    res_t r;
    r.x    = COORDW'(x);
    r.y    = COORDW'(y);
    r.iter = ITW'(it);
    r.esc  = esc;
    return r;
  endfunction

  // Reference iteration written straight from the fixed-point recurrence.
  function automatic res_t modelPoint(input int cr, input int ci, input int x, input int y);
    logic signed [W-1:0]   zx, zy;
    logic signed [2*W-1:0] px, py, pxy;
    logic [2*W:0]          mag, lim;
    int                    k;
    logic                  esc;
    zx  = '0;
    zy  = '0;
    k   = 0;
    esc = 1'b0;
    lim = 65'd1 << (2 * FRAC + 2);
    while (!esc && k < IMAX) begin
      px  = zx * zx;
      py  = zy * zy;
      pxy = zx * zy;
      zx  = W'((px - py) >>> FRAC) + W'(cr);
      zy  = W'(pxy >>> (FRAC - 1)) + W'(ci);
      px  = zx * zx;
      py  = zy * zy;
      mag = {1'b0, px} + {1'b0, py};
      esc = mag > lim;
      k++;
    end
    return mkRes(x, y, k, esc);
  endfunction

  // Offer one point, wait (bounded) for acceptance, record its expected result.
  task automatic applyStimulus(input int cr, input int ci, input res_t expd);
    int waited;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_cre   = W'(cr);
    bus.in_cim   = W'(ci);
    bus.in_x     = expd.x;
    bus.in_y     = expd.y;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    total++;
    assert (bus.in_ready === 1'b1) else begin
      bad++;
      $error("[TB] FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    end
    if (bus.in_ready === 1'b1) sbQ.push_back(expd);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Compare the presented result with the oldest pending expectation; pop
  // it when the handshake completes at the coming rising edge.
  task automatic checkOutput();
    res_t obs, expd;
    obs = {bus.out_x, bus.out_y, bus.out_iter, bus.out_escaped};
    total++;
    assert (sbQ.size() > 0) else begin
      bad++;
      $error("[TB] FAIL unexpected_output got x=%0d y=%0d iter=%0d esc=%0d required none",
             obs.x, obs.y, obs.iter, obs.esc);
    end
    if (sbQ.size() > 0) begin
      expd = sbQ[0];
      total++;
      assert (obs === expd) else begin
        bad++;
        $error("[TB] FAIL result got x=%0d y=%0d iter=%0d esc=%0d required x=%0d y=%0d iter=%0d esc=%0d",
               obs.x, obs.y, obs.iter, obs.esc, expd.x, expd.y, expd.iter, expd.esc);
      end
      if (bus.out_ready === 1'b1) void'(sbQ.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) checkOutput();
  end

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    total++;
    assert (sbQ.size() == 0) else begin
      bad++;
      $error("[TB] FAIL drain_timeout pending=%0d required=0", sbQ.size());
    end
    #1;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic expd);
    total++;
    assert (obs === expd) else begin
      bad++;
      $error("[TB] FAIL %s got=%b required=%b", tag, obs, expd);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int expd);
    total++;
    assert (obs == expd) else begin
      bad++;
      $error("[TB] FAIL %s got=%0d required=%0d", tag, obs, expd);
    end
  endtask

  initial begin
    int   accepted;
    int   waited;
    int   cycles;
    int   cr, ci;
    logic sawValid;
    logic stopOffer;

    bus.in_valid  = 1'b0;
    bus.in_cre    = '0;
    bus.in_cim    = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkBit("rst_out_valid", bus.out_valid, 1'b0);
    checkBit("rst_in_ready", bus.in_ready, 1'b0);
    checkInt("rst_out_x", int'(bus.out_x), 0);
    checkInt("rst_out_iter", int'(bus.out_iter), 0);
    checkBit("rst_out_escaped", bus.out_escaped, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    checkBit("ready_after_reset", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Iteration cap: c=0 and c=-2 (|z|^2 sits exactly at 4, which does not escape)
    applyStimulus(0, 0, mkRes(1, 1, 15, 1'b0));
    applyStimulus(-2 * ONE, 0, mkRes(2, 3, 15, 1'b0));
    waitDrain(300);

    // Escape: c=2 escapes at k=2, c=3 escapes at k=1
    applyStimulus(2 * ONE, 0, mkRes(4, 5, 2, 1'b1));
    applyStimulus(3 * ONE, 0, mkRes(6, 7, 1, 1'b1));
    waitDrain(100);

    // Latency of an escape-at-1 point on an idle engine
    applyStimulus(3 * ONE, 0, mkRes(3, 4, 1, 1'b1));
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.out_valid && cycles < 50);
    checkInt("latency_k1", cycles, DEPTH + 1);
    waitDrain(50);

    // Ordering: B retires long before A but must come out second
    applyStimulus(0, 0, mkRes(1, 1, 15, 1'b0));
    applyStimulus(3 * ONE, 0, mkRes(2, 2, 1, 1'b1));
    waitDrain(300);

    // Assorted points in [-2,2]^2 checked against the reference model
    for (int i = 0; i < 6; i++) begin
      cr = int'($urandom_range(0, 2 * ONE * 2)) - 2 * ONE;
      ci = int'($urandom_range(0, 2 * ONE * 2)) - 2 * ONE;
      applyStimulus(cr, ci, modelPoint(cr, ci, 20 + i, 40 + i));
    end
    waitDrain(600);

    // Backpressure: only 2^ROBW points may be outstanding
    bus.out_ready = 1'b0;
    accepted      = 0;
    stopOffer     = 1'b0;
    for (int i = 0; i < 10 && !stopOffer; i++) begin
      bus.in_valid = 1'b1;
      bus.in_cre   = W'(3 * ONE);
      bus.in_cim   = '0;
      bus.in_x     = COORDW'(100 + i);
      bus.in_y     = COORDW'(200 + i);
      waited       = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.in_ready) begin
        stopOffer = 1'b1;
      end else begin
        sbQ.push_back(mkRes(100 + i, 200 + i, 1, 1'b1));
        accepted++;
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkInt("bp_accepted", accepted, 8);
    @(negedge clk);
    checkBit("bp_ready_low", bus.in_ready, 1'b0);
    checkBit("bp_out_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkBit("bp_ready_same_cycle", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkBit("bp_ready_returns", bus.in_ready, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    waitDrain(100);

    // Reset with points in flight and results waiting in the reorder buffer
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(3 * ONE, 0, mkRes(50 + i, 60 + i, 1, 1'b1));
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, mkRes(70 + i, 80 + i, 15, 1'b0));
    repeat (8) @(posedge clk);
    #1;
    checkBit("pre_reset_out_valid", bus.out_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    checkBit("async_reset_out_valid", bus.out_valid, 1'b0);
    checkBit("async_reset_in_ready", bus.in_ready, 1'b0);
    checkInt("async_reset_out_y", int'(bus.out_y), 0);
    sbQ.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkBit("ready_after_midreset", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    sawValid      = 1'b0;
    repeat (80) begin
      @(negedge clk);
      sawValid = sawValid | bus.out_valid;
    end
    checkBit("no_stale_output", sawValid, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(2 * ONE, 0, mkRes(7, 9, 2, 1'b1));
    waitDrain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
